// File: rtl/axi_wr_burst_master.sv
// AXI4 write burst master: splits one command into sub-bursts that never cross a 4KB
// boundary, streams source data through the W channel and folds the B responses.
module axi_wr_burst_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      ARESTN,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [8:0]                cmd_beats,
  input  logic [2:0]                cmd_size,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic [ADDR_WIDTH-1:0]     AWADDR,
  output logic [7:0]                AWLEN,
  output logic [2:0]                AWSIZE,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [DATA_WIDTH-1:0]     WDATA,
  output logic [DATA_WIDTH/8-1:0]   WSTRB,
  output logic                      WLAST,
  output logic                      WVALID,
  input  logic                      WREADY,
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY,
  output logic                      done,
  output logic [1:0]                done_resp
);

  localparam int unsigned StrbW   = DATA_WIDTH / 8;
  localparam int unsigned LaneW   = $clog2(StrbW);
  localparam logic [2:0]  MaxSize = 3'(LaneW);

  typedef enum logic [2:0] {StIdle, StAddr, StData, StResp, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [8:0]            remaining_q, remaining_d;
  logic [2:0]            size_q, size_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [1:0]            resp_acc_q, resp_acc_d;
  logic [1:0]            done_resp_q, done_resp_d;

  // Beats that fit before the next 4KB boundary, capped by what is left of the command.
  function automatic logic [8:0] sub_beats(logic [11:0] page_off, logic [8:0] rem,
                                           logic [2:0] size);
    logic [12:0] room;
    room = (13'd4096 - {1'b0, page_off}) >> size;
    return ({4'd0, rem} < room) ? rem : room[8:0];
  endfunction

  // Worst response wins; EXOKAY carries no error information for a write.
  function automatic logic [1:0] fold(logic [1:0] acc, logic [1:0] resp);
    logic [1:0] r;
    r = (resp == 2'b01) ? 2'b00 : resp;
    return (r > acc) ? r : acc;
  endfunction

  logic [2:0]            cmd_size_c;
  logic [ADDR_WIDTH-1:0] cmd_addr_c;
  logic [8:0]            cmd_beats_c;
  logic [8:0]            sub_c;

  always_comb begin
    cmd_size_c  = (cmd_size > MaxSize) ? MaxSize : cmd_size;
    cmd_addr_c  = cmd_addr & ~((ADDR_WIDTH'(1) << cmd_size_c) - ADDR_WIDTH'(1));
    cmd_beats_c = (cmd_beats == 9'd0)   ? 9'd1   :
                  (cmd_beats > 9'd256)  ? 9'd256 : cmd_beats;
    if (state_q == StIdle) begin
      sub_c = sub_beats(cmd_addr_c[11:0], cmd_beats_c, cmd_size_c);
    end else begin
      sub_c = sub_beats(addr_q[11:0], remaining_q, size_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    size_d      = size_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    resp_acc_d  = resp_acc_q;
    done_resp_d = done_resp_q;
    cmd_ready   = 1'b0;
    AWVALID     = 1'b0;
    WVALID      = 1'b0;
    wr_ready    = 1'b0;
    WLAST       = 1'b0;
    BREADY      = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d      = cmd_addr_c;
          size_d      = cmd_size_c;
          len_d       = 8'(sub_c - 9'd1);
          beat_cnt_d  = 8'(sub_c - 9'd1);
          remaining_d = cmd_beats_c - sub_c;
          resp_acc_d  = 2'b00;
          state_d     = StAddr;
        end
      end
      StAddr: begin
        AWVALID = 1'b1;
        if (AWREADY) state_d = StData;
      end
      StData: begin
        WVALID   = wr_valid;
        wr_ready = WREADY;
        WLAST    = (beat_cnt_q == 8'd0);
        if (wr_valid && WREADY) begin
          // addr_q tracks the beat address, so it already holds the next AWADDR at the end
          addr_d     = addr_q + (ADDR_WIDTH'(1) << size_q);
          beat_cnt_d = beat_cnt_q - 8'd1;
          if (beat_cnt_q == 8'd0) state_d = StResp;
        end
      end
      StResp: begin
        BREADY = 1'b1;
        if (BVALID) begin
          resp_acc_d = fold(resp_acc_q, BRESP);
          if (remaining_q != 9'd0) begin
            len_d       = 8'(sub_c - 9'd1);
            beat_cnt_d  = 8'(sub_c - 9'd1);
            remaining_d = remaining_q - sub_c;
            state_d     = StAddr;
          end else begin
            done_resp_d = fold(resp_acc_q, BRESP);
            state_d     = StDone;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge ARESTN) begin
    if (!ARESTN) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      size_q      <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      resp_acc_q  <= '0;
      done_resp_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      size_q      <= size_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      resp_acc_q  <= resp_acc_d;
      done_resp_q <= done_resp_d;
    end
  end

  logic [StrbW-1:0] strb_base;

  always_comb begin
    strb_base = {StrbW{1'b1}} >> (StrbW - (32'd1 << size_q));
    WSTRB     = (state_q == StData) ? (strb_base << addr_q[LaneW-1:0]) : '0;
  end

  assign AWADDR    = addr_q;
  assign AWLEN     = len_q;
  assign AWSIZE    = size_q;
  assign WDATA     = wr_data;
  assign done_resp = done_resp_q;

endmodule

// File: tb/tb_axi_wr_burst_master.sv
// Scoreboard bench for axi_wr_burst_master: directed commands push expected AW/W/done
// entries; an independent monitor pops and compares at every handshake.
module tb_axi_wr_burst_master;

  logic        clk = 1'b0;
  logic        ARESTN = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_addr = '0;
  logic [8:0]  cmd_beats = '0;
  logic [2:0]  cmd_size = '0;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [15:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic        done;
  logic [1:0]  done_resp;

  axi_wr_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .clk       (clk),
    .ARESTN    (ARESTN),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_beats (cmd_beats),
    .cmd_size  (cmd_size),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .AWADDR    (AWADDR),
    .AWLEN     (AWLEN),
    .AWSIZE    (AWSIZE),
    .AWVALID   (AWVALID),
    .AWREADY   (AWREADY),
    .WDATA     (WDATA),
    .WSTRB     (WSTRB),
    .WLAST     (WLAST),
    .WVALID    (WVALID),
    .WREADY    (WREADY),
    .BRESP     (BRESP),
    .BVALID    (BVALID),
    .BREADY    (BREADY),
    .done      (done),
    .done_resp (done_resp)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {logic [15:0] addr; logic [7:0] len; logic [2:0] size;} aw_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb; logic last;} w_t;

  aw_t         exp_aw[$];
  w_t          exp_w[$];
  logic [1:0]  exp_done[$];
  logic [31:0] src_q[$];
  logic [1:0]  bresp_q[$];

  int          vectors = 0;
  int          miscompares = 0;
  int          w_seen = 0;
  bit          outstanding = 1'b0;
  bit          wr_toggle = 1'b0;
  logic [31:0] data_seed = 32'h1234_5678;

  // Monitor / scoreboard checker
  initial begin
    aw_t        ea;
    w_t         ew;
    logic [1:0] ed;
    forever begin
      @(negedge clk);
      if (!ARESTN) begin
        outstanding = 1'b0;
      end else begin
        if (AWVALID && AWREADY) begin
          vectors++;
          if (exp_aw.size() == 0) begin
            $display("FAIL aw_unexpected: got addr=%h len=%0d size=%0d, required no AW",
                     AWADDR, AWLEN, AWSIZE);
            miscompares++;
          end else begin
            ea = exp_aw.pop_front();
            if ({AWADDR, AWLEN, AWSIZE} !== ea || outstanding) begin
              $display("FAIL aw: got addr=%h len=%0d size=%0d outstanding=%0b, required addr=%h len=%0d size=%0d outstanding=0",
                       AWADDR, AWLEN, AWSIZE, outstanding, ea.addr, ea.len, ea.size);
              miscompares++;
            end
          end
          outstanding = 1'b1;
        end
        if (WVALID && WREADY) begin
          vectors++;
          w_seen++;
          if (exp_w.size() == 0) begin
            $display("FAIL w_unexpected: got data=%h strb=%h last=%b, required no beat",
                     WDATA, WSTRB, WLAST);
            miscompares++;
          end else begin
            ew = exp_w.pop_front();
            if ({WDATA, WSTRB, WLAST} !== ew) begin
              $display("FAIL w_beat: got data=%h strb=%h last=%b, required data=%h strb=%h last=%b",
                       WDATA, WSTRB, WLAST, ew.data, ew.strb, ew.last);
              miscompares++;
            end
          end
        end
        if (BVALID && BREADY) outstanding = 1'b0;
        if (done) begin
          vectors++;
          if (exp_done.size() == 0) begin
            $display("FAIL done_unexpected: got done resp=%0d, required no done", done_resp);
            miscompares++;
          end else begin
            ed = exp_done.pop_front();
            if (done_resp !== ed) begin
              $display("FAIL done_resp: got %0d, required %0d", done_resp, ed);
              miscompares++;
            end
          end
        end
      end
    end
  end

  // Slave model: AW/W readiness patterns, one B per WLAST
  initial begin
    bit wl_f, b_f;
    int cyc = 0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    forever begin
      @(negedge clk);
      wl_f = WVALID && WREADY && WLAST;
      b_f  = BVALID && BREADY;
      @(posedge clk); #1;
      cyc++;
      AWREADY = (cyc % 3 == 0);
      WREADY  = wr_toggle ? (cyc % 2 == 0) : 1'b1;
      if (!ARESTN) begin
        BVALID = 1'b0;
      end else begin
        if (b_f) BVALID = 1'b0;
        if (wl_f) begin
          BVALID = 1'b1;
          BRESP  = 2'b00;
          if (bresp_q.size() > 0) BRESP = bresp_q.pop_front();
        end
      end
    end
  end

  // Data source
  initial begin
    bit s_f;
    wr_valid = 1'b0; wr_data = '0;
    forever begin
      @(negedge clk);
      s_f = wr_valid && wr_ready;
      @(posedge clk); #1;
      if (s_f && src_q.size() > 0) src_q.delete(0);
      if (src_q.size() > 0) begin
        wr_valid = 1'b1; wr_data = src_q[0];
      end else begin
        wr_valid = 1'b0; wr_data = '0;
      end
    end
  end

  task automatic push_aw(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s);
    aw_t e;
    e.addr = a; e.len = l; e.size = s;
    exp_aw.push_back(e);
  endtask

  task automatic push_w(input logic [3:0] strb, input bit last);
    w_t e;
    e.data = data_seed; e.strb = strb; e.last = last;
    src_q.push_back(data_seed);
    exp_w.push_back(e);
    data_seed = data_seed * 32'd1103515245 + 32'd12345;
  endtask

  task automatic push_sub(input int n, input logic [3:0] strb);
    for (int i = 0; i < n; i++) push_w(strb, i == n - 1);
  endtask

  task automatic flush_all();
    exp_aw.delete(); exp_w.delete(); exp_done.delete(); src_q.delete(); bresp_q.delete();
  endtask

  task automatic issue(input logic [15:0] a, input logic [8:0] b, input logic [2:0] s);
    int n = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_beats = b; cmd_size = s;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd(input string name, input logic [1:0] resp);
    int n = 0;
    while (exp_done.size() > 0 && n < 3000) begin @(negedge clk); #1; n++; end
    vectors++;
    if (exp_done.size() > 0 || exp_aw.size() > 0 || exp_w.size() > 0) begin
      $display("FAIL %s_drain: got pending aw=%0d w=%0d done=%0d, required all 0",
               name, exp_aw.size(), exp_w.size(), exp_done.size());
      miscompares++;
    end
    flush_all();
    repeat (3) @(negedge clk);
    vectors++;
    if (done_resp !== resp) begin
      $display("FAIL %s_held: got done_resp=%0d, required %0d", name, done_resp, resp);
      miscompares++;
    end
  endtask

  initial begin
    int base, n;
    #3 ARESTN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({AWVALID, WVALID, WLAST, BREADY, done, wr_ready, done_resp, AWADDR, AWLEN, AWSIZE,
         WSTRB} !== '0) begin
      $display("FAIL reset_outputs: got aw=%b w=%b last=%b br=%b done=%b resp=%0d addr=%h len=%0d size=%0d strb=%h, required all 0",
               AWVALID, WVALID, WLAST, BREADY, done, done_resp, AWADDR, AWLEN, AWSIZE, WSTRB);
      miscompares++;
    end
    @(negedge clk); ARESTN = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready);
      miscompares++;
    end

    // Single aligned burst
    push_aw(16'h0100, 8'd3, 3'd2); push_sub(4, 4'hF); exp_done.push_back(2'b00);
    issue(16'h0100, 9'd4, 3'd2);
    finish_cmd("basic", 2'b00);

    // Split at 4KB
    push_aw(16'h0FF0, 8'd3, 3'd2); push_sub(4, 4'hF);
    push_aw(16'h1000, 8'd3, 3'd2); push_sub(4, 4'hF); exp_done.push_back(2'b00);
    issue(16'h0FF0, 9'd8, 3'd2);
    finish_cmd("split4k", 2'b00);

    // Ends exactly on the boundary
    push_aw(16'h0FE0, 8'd7, 3'd2); push_sub(8, 4'hF); exp_done.push_back(2'b00);
    issue(16'h0FE0, 9'd8, 3'd2);
    finish_cmd("edge4k", 2'b00);

    // 256 beats split 64/192
    push_aw(16'h0F00, 8'd63, 3'd2); push_sub(64, 4'hF);
    push_aw(16'h1000, 8'd191, 3'd2); push_sub(192, 4'hF); exp_done.push_back(2'b00);
    issue(16'h0F00, 9'd256, 3'd2);
    finish_cmd("max256", 2'b00);

    // Narrow byte beats with WREADY toggling
    wr_toggle = 1'b1;
    push_aw(16'h0103, 8'd1, 3'd0); push_w(4'h8, 1'b0); push_w(4'h1, 1'b1);
    exp_done.push_back(2'b00);
    issue(16'h0103, 9'd2, 3'd0);
    finish_cmd("narrow8", 2'b00);

    // Halfword beats
    push_aw(16'h0102, 8'd2, 3'd1); push_w(4'hC, 1'b0); push_w(4'h3, 1'b0); push_w(4'hC, 1'b1);
    exp_done.push_back(2'b00);
    issue(16'h0102, 9'd3, 3'd1);
    finish_cmd("narrow16", 2'b00);
    wr_toggle = 1'b0;

    // Response folding across sub-bursts
    push_aw(16'h0FF8, 8'd1, 3'd2); push_sub(2, 4'hF);
    push_aw(16'h1000, 8'd1, 3'd2); push_sub(2, 4'hF);
    bresp_q.push_back(2'b10); bresp_q.push_back(2'b00); exp_done.push_back(2'b10);
    issue(16'h0FF8, 9'd4, 3'd2);
    finish_cmd("slverr", 2'b10);

    push_aw(16'h0FF8, 8'd1, 3'd2); push_sub(2, 4'hF);
    push_aw(16'h1000, 8'd1, 3'd2); push_sub(2, 4'hF);
    bresp_q.push_back(2'b11); bresp_q.push_back(2'b10); exp_done.push_back(2'b11);
    issue(16'h0FF8, 9'd4, 3'd2);
    finish_cmd("decerr", 2'b11);

    // EXOKAY folds as OKAY; accumulator must start clean
    push_aw(16'h0400, 8'd1, 3'd2); push_sub(2, 4'hF);
    bresp_q.push_back(2'b01); exp_done.push_back(2'b00);
    issue(16'h0400, 9'd2, 3'd2);
    finish_cmd("exokay", 2'b00);

    // beats=0 -> 1, size 7 clamps to 2, address aligned down
    push_aw(16'h0044, 8'd0, 3'd2); push_sub(1, 4'hF); exp_done.push_back(2'b00);
    issue(16'h0046, 9'd0, 3'd7);
    finish_cmd("clamp", 2'b00);

    // Reset during beat 2 of 4
    push_aw(16'h0200, 8'd3, 3'd2); push_sub(4, 4'hF);
    base = w_seen;
    issue(16'h0200, 9'd4, 3'd2);
    n = 0;
    while (w_seen < base + 2 && n < 500) begin @(negedge clk); #1; n++; end
    vectors++;
    if (w_seen < base + 2) begin
      $display("FAIL rst_reach_beat2: got %0d beats, required 2", w_seen - base);
      miscompares++;
    end
    ARESTN = 1'b0;
    #1;
    vectors++;
    if ({AWVALID, WVALID, wr_ready, WLAST, BREADY, done} !== 6'b0) begin
      $display("FAIL rst_valids: got aw=%b w=%b wr_ready=%b last=%b br=%b done=%b, required all 0",
               AWVALID, WVALID, wr_ready, WLAST, BREADY, done);
      miscompares++;
    end
    flush_all();
    repeat (3) @(negedge clk);
    ARESTN = 1'b1;
    repeat (2) @(negedge clk);
    push_aw(16'h0300, 8'd3, 3'd2); push_sub(4, 4'hF); exp_done.push_back(2'b00);
    issue(16'h0300, 9'd4, 3'd2);
    finish_cmd("after_rst", 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_wr_burst_master.md
AXI_WR_BURST_MASTER -- requirements
Module: axi_wr_burst_master

Interface
REQ-001 DATA_WIDTH, 32, WDATA width in bits; legal 32/64/128.
REQ-002 ADDR_WIDTH, 16, byte-address width; minimum 13.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 ARESTN  in  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  high only in IDLE.
REQ-007 cmd_addr  in  ADDR_WIDTH  start byte address.
REQ-008 cmd_beats  in  9  total beats, 1..256; 0 treated as 1.
REQ-009 cmd_size  in  3  bytes/beat = 2^cmd_size; values above log2(DATA_WIDTH/8) clamp to it.
REQ-010 wr_valid  in  1  source data valid.
REQ-011 wr_ready  out  1  source data accepted.
REQ-012 wr_data  in  DATA_WIDTH  source data; lanes pre-positioned by source.
REQ-013 AWADDR  out  ADDR_WIDTH  sub-burst address.
REQ-014 AWLEN  out  8  sub-burst beats minus one.
REQ-015 AWSIZE  out  3  latched, clamped cmd_size.
REQ-016 AWVALID / AWREADY  out / in  1  address handshake.
REQ-017 WDATA  out  DATA_WIDTH  wr_data pass-through.
REQ-018 WSTRB  out  DATA_WIDTH/8  active byte lanes.
REQ-019 WLAST  out  1  last beat of current sub-burst.
REQ-020 WVALID / WREADY  out / in  1  data handshake.
REQ-021 BRESP / BVALID / BREADY  in / in / out  2/1/1  write response.
REQ-022 done  out  1  one-cycle pulse at command completion.
REQ-023 done_resp  out  2  aggregated response, valid with done, held until next done.

Function
REQ-024 States IDLE, ADDR, DATA, RESP, DONE; IDLE->ADDR on cmd_valid&&cmd_ready, latching addr (low cmd_size bits zeroed), beats, and size.
REQ-025 Sub-burst beats = min(remaining, (4096 - addr[11:0]) >> size); no sub-burst crosses a 4KB boundary.
REQ-026 ADDR: AWVALID high, AWADDR/AWLEN/AWSIZE stable until AWREADY; on handshake -> DATA.
REQ-027 DATA: WVALID = wr_valid, wr_ready = WREADY, combinational; back-to-back beats without bubble; beat counted on WVALID&&WREADY.
REQ-028 WLAST high on the final beat of each sub-burst; after that beat -> RESP.
REQ-029 WSTRB = ((1 << 2^size) - 1) << (beat_addr mod (DATA_WIDTH/8)); beat_addr += 2^size per beat.
REQ-030 RESP: BREADY high; on BVALID fold BRESP; remaining > 0 -> ADDR with next address, else -> DONE.
REQ-031 Fold priority DECERR > SLVERR > OKAY; EXOKAY folds as OKAY; accumulator cleared at command accept.
REQ-032 DONE: done = 1 for one cycle, done_resp updated, -> IDLE.
REQ-033 Only one sub-burst outstanding; next AWVALID never before previous B handshake.
REQ-034 wr_ready = 0 and WVALID = 0 outside DATA; cmd_valid ignored outside IDLE.

Reset
REQ-035 ARESTN low: state IDLE; AWVALID, WVALID, WLAST, BREADY, done = 0; done_resp = OKAY; AWADDR, AWLEN, AWSIZE, WSTRB = 0; cmd_ready = 1 on first clk after release.
REQ-036 Reset mid-transaction abandons the command immediately; no done pulse.

Verification
REQ-037 DW=32, addr 0x0100, beats 4, size 2, all OKAY -> one AW (0x0100, AWLEN 3), 4 beats, WSTRB 0xF, WLAST on beat 4, done_resp OKAY.
REQ-038 addr 0x0FF0, beats 8, size 2 -> AW 0x0FF0 AWLEN 3, B, then AW 0x1000 AWLEN 3; one done.
REQ-039 addr 0x0FE0, beats 8, size 2 -> single AW AWLEN 7 ending at 0x0FFF; addr 0x0F00, beats 256 -> AWLEN 63 then 0x1000 AWLEN 191.
REQ-040 Narrow: size 0, addr 0x0103, beats 2 -> WSTRB 0x8 then 0x1; WREADY toggling -> no beat lost or duplicated.
REQ-041 Split command, first BRESP SLVERR, second OKAY -> done_resp SLVERR; DECERR then SLVERR -> DECERR.
REQ-042 ARESTN low during beat 2 of 4 -> all valids 0 immediately, no done, new command afterwards completes OKAY.
